ex_operand_b_stage: RTL and testbench

ID/EX pipeline stage for ALU operand B in the 16-bit ThinPad CPU. Latches the decoder's operand-B select code (00 = ry, 01 = immediate, 10/11 = zero) together with ry data, immediate and destination info. In EX it produces the final operand B, forwarding from EX/MEM and MEM/WB, and flags load-use hazards back to the hazard controller. It is the consumer end of the operand-B select path driven by the ID-stage control decoder.

---
 rtl/ex_operand_b_stage.sv | 131 +++++++++++++
 tb/tb_ex_operand_b_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_b_stage.sv
// ID/EX operand-B stage for the 16-bit ThinPad CPU: latches the operand-B select path,
// resolves forwarding in EX and flags load-use hazards. Optional macro: OPB_FORWARD_EN.
module ex_operand_b_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [1:0]  sel_b_in,
  input  logic [3:0]  ry_addr_in,
  input  logic [15:0] ry_data_in,
  input  logic [15:0] imm_in,
  input  logic [3:0]  dst_addr_in,
  input  logic        dst_wr_en_in,
  input  logic        mem_read_in,
  input  logic        exmem_wr_en,
  input  logic [3:0]  exmem_wr_addr,
  input  logic [15:0] exmem_wr_data,
  input  logic        memwb_wr_en,
  input  logic [3:0]  memwb_wr_addr,
  input  logic [15:0] memwb_wr_data,
  output logic [15:0] op_b,
  output logic        valid_q,
  output logic [1:0]  sel_b_q,
  output logic [3:0]  dst_addr_q,
  output logic        dst_wr_en_q,
  output logic        mem_read_q,
  output logic        load_use_stall
);

  localparam logic [3:0] NO_REG  = 4'hF;
  localparam logic [1:0] SEL_RY  = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;

  logic [3:0]  ry_addr_q;
  logic [15:0] ry_data_q, imm_q;

  logic        valid_d, dst_wr_en_d, mem_read_d;
  logic [1:0]  sel_b_d;
  logic [3:0]  ry_addr_d, dst_addr_d;
  logic [15:0] ry_data_d, imm_d;
  logic [15:0] ry_val;
  logic        raw_hit;

  // Handshake: while load_use_stall is high the ID stage holds its instruction and
  // this stage inserts a bubble; stall freezes every field, flush overrides both.
`ifdef OPB_FORWARD_EN
  assign raw_hit = valid_q && mem_read_q && dst_wr_en_q && (ry_addr_in == dst_addr_q);
`else
  // Without forwarding any in-flight writer of ry is a hazard; MEM/WB is covered by
  // the register file writing before it is read.
  assign raw_hit = (valid_q && dst_wr_en_q && (ry_addr_in == dst_addr_q)) ||
                   (exmem_wr_en && (ry_addr_in == exmem_wr_addr));
  logic unused_fwd;
  assign unused_fwd = ^{ry_addr_q, exmem_wr_data, memwb_wr_en, memwb_wr_addr, memwb_wr_data};
`endif

  assign load_use_stall = !rst && valid_in && (sel_b_in == SEL_RY) && raw_hit;

  always_comb begin
    ry_val = ry_data_q;
`ifdef OPB_FORWARD_EN
    if (exmem_wr_en && (exmem_wr_addr == ry_addr_q) && (ry_addr_q != NO_REG))
      ry_val = exmem_wr_data;
    else if (memwb_wr_en && (memwb_wr_addr == ry_addr_q) && (ry_addr_q != NO_REG))
      ry_val = memwb_wr_data;
`endif
    op_b = 16'h0000;
    if (valid_q) begin
      case (sel_b_q)
        SEL_RY:  op_b = ry_val;
        SEL_IMM: op_b = imm_q;
        default: op_b = 16'h0000;
      endcase
    end
  end

  always_comb begin
    valid_d     = valid_q;
    sel_b_d     = sel_b_q;
    ry_addr_d   = ry_addr_q;
    ry_data_d   = ry_data_q;
    imm_d       = imm_q;
    dst_addr_d  = dst_addr_q;
    dst_wr_en_d = dst_wr_en_q;
    mem_read_d  = mem_read_q;
    if (flush || (!stall && load_use_stall)) begin
      valid_d     = 1'b0;
      sel_b_d     = SEL_ZERO;
      ry_addr_d   = NO_REG;
      ry_data_d   = 16'h0000;
      imm_d       = 16'h0000;
      dst_addr_d  = NO_REG;
      dst_wr_en_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (!stall) begin
      valid_d     = valid_in;
      sel_b_d     = sel_b_in;
      ry_addr_d   = ry_addr_in;
      ry_data_d   = ry_data_in;
      imm_d       = imm_in;
      dst_addr_d  = dst_addr_in;
      dst_wr_en_d = dst_wr_en_in;
      mem_read_d  = mem_read_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      sel_b_q     <= SEL_ZERO;
      ry_addr_q   <= NO_REG;
      ry_data_q   <= 16'h0000;
      imm_q       <= 16'h0000;
      dst_addr_q  <= NO_REG;
      dst_wr_en_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      sel_b_q     <= sel_b_d;
      ry_addr_q   <= ry_addr_d;
      ry_data_q   <= ry_data_d;
      imm_q       <= imm_d;
      dst_addr_q  <= dst_addr_d;
      dst_wr_en_q <= dst_wr_en_d;
      mem_read_q  <= mem_read_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_b_stage.sv
// Self-checking bench for ex_operand_b_stage: directed steps from the test plan, then
// randomized traffic against a stage-level reference model (honours OPB_FORWARD_EN).
module tb_ex_operand_b_stage;

  logic        clk, rst, stall, flush, valid_in;
  logic [1:0]  sel_b_in;
  logic [3:0]  ry_addr_in, dst_addr_in, exmem_wr_addr, memwb_wr_addr;
  logic [15:0] ry_data_in, imm_in, exmem_wr_data, memwb_wr_data;
  logic        dst_wr_en_in, mem_read_in, exmem_wr_en, memwb_wr_en;
  logic [15:0] op_b;
  logic        valid_q, dst_wr_en_q, mem_read_q, load_use_stall;
  logic [1:0]  sel_b_q;
  logic [3:0]  dst_addr_q;

  int tests_run = 0;
  int tests_failed = 0;

  ex_operand_b_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .sel_b_in(sel_b_in), .ry_addr_in(ry_addr_in), .ry_data_in(ry_data_in),
    .imm_in(imm_in), .dst_addr_in(dst_addr_in), .dst_wr_en_in(dst_wr_en_in),
    .mem_read_in(mem_read_in), .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr),
    .exmem_wr_data(exmem_wr_data), .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr),
    .memwb_wr_data(memwb_wr_data), .op_b(op_b), .valid_q(valid_q), .sel_b_q(sel_b_q),
    .dst_addr_q(dst_addr_q), .dst_wr_en_q(dst_wr_en_q), .mem_read_q(mem_read_q),
    .load_use_stall(load_use_stall)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: contents of the EX slot as an instruction record
  typedef struct packed {
    logic        valid;
    logic [1:0]  sel;
    logic [3:0]  ry_addr;
    logic [15:0] ry_data;
    logic [15:0] imm;
    logic [3:0]  dst;
    logic        wr_en;
    logic        mem_read;
  } stg_t;

  localparam stg_t BUBBLE = '{valid: 1'b0, sel: 2'b10, ry_addr: 4'hF, ry_data: 16'h0,
                              imm: 16'h0, dst: 4'hF, wr_en: 1'b0, mem_read: 1'b0};
  stg_t m;

  // Newest producer is applied last so it overrides older ones.
  function automatic logic [15:0] ry_value(stg_t s);
    logic [15:0] v;
    v = s.ry_data;
`ifdef OPB_FORWARD_EN
    if (memwb_wr_en && memwb_wr_addr == s.ry_addr && s.ry_addr != 4'hF) v = memwb_wr_data;
    if (exmem_wr_en && exmem_wr_addr == s.ry_addr && s.ry_addr != 4'hF) v = exmem_wr_data;
`endif
    return v;
  endfunction

  function automatic logic [15:0] exp_op_b(stg_t s);
    if (!s.valid) return 16'h0;
    if (s.sel == 2'b00) return ry_value(s);
    if (s.sel == 2'b01) return s.imm;
    return 16'h0;
  endfunction

  function automatic logic exp_lus(stg_t s);
    if (rst || !valid_in || sel_b_in != 2'b00) return 1'b0;
`ifdef OPB_FORWARD_EN
    return s.valid && s.mem_read && s.wr_en && (ry_addr_in == s.dst);
`else
    return (s.valid && s.wr_en && (ry_addr_in == s.dst)) ||
           (exmem_wr_en && (ry_addr_in == exmem_wr_addr));
`endif
  endfunction

  function automatic stg_t model_next(stg_t s);
    stg_t n;
    if (rst || flush) return BUBBLE;
    if (stall) return s;
    if (exp_lus(s)) return BUBBLE;
    n = '{valid: valid_in, sel: sel_b_in, ry_addr: ry_addr_in, ry_data: ry_data_in,
          imm: imm_in, dst: dst_addr_in, wr_en: dst_wr_en_in, mem_read: mem_read_in};
    return n;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    check({tag, ".op_b"}, op_b, exp_op_b(m));
    check({tag, ".lus"}, {15'h0, load_use_stall}, {15'h0, exp_lus(m)});
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".valid_q"}, {15'h0, valid_q}, {15'h0, m.valid});
    check({tag, ".sel_b_q"}, {14'h0, sel_b_q}, {14'h0, m.sel});
    check({tag, ".dst_addr_q"}, {12'h0, dst_addr_q}, {12'h0, m.dst});
    check({tag, ".dst_wr_en_q"}, {15'h0, dst_wr_en_q}, {15'h0, m.wr_en});
    check({tag, ".mem_read_q"}, {15'h0, mem_read_q}, {15'h0, m.mem_read});
  endtask

  // driver tasks
  task automatic drive_idle();
    stall = 0; flush = 0; valid_in = 0; sel_b_in = 2'b10;
    ry_addr_in = 4'h0; ry_data_in = 16'h0; imm_in = 16'h0;
    dst_addr_in = 4'h0; dst_wr_en_in = 0; mem_read_in = 0;
    exmem_wr_en = 0; exmem_wr_addr = 4'h0; exmem_wr_data = 16'h0;
    memwb_wr_en = 0; memwb_wr_addr = 4'h0; memwb_wr_data = 16'h0;
  endtask

  task automatic drive_id(input logic [1:0] sel, input logic [3:0] ry, input logic [15:0] ryd,
                          input logic [15:0] imm, input logic [3:0] dst, input logic wr,
                          input logic ld);
    valid_in = 1; sel_b_in = sel; ry_addr_in = ry; ry_data_in = ryd; imm_in = imm;
    dst_addr_in = dst; dst_wr_en_in = wr; mem_read_in = ld;
  endtask

  task automatic step(input string tag);
    stg_t nxt;
    #1;
    check_comb({tag, ".pre"});
    nxt = model_next(m);
    @(posedge clk);
    #1;
    m = nxt;
    check_regs(tag);
    check_comb({tag, ".post"});
  endtask

  task automatic randomize_inputs();
    stall = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 7) == 0);
    valid_in = ($urandom_range(0, 3) != 0);
    sel_b_in = 2'($urandom_range(0, 3));
    ry_addr_in = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 5));
    ry_data_in = 16'($urandom);
    imm_in = 16'($urandom);
    dst_addr_in = 4'($urandom_range(0, 5));
    dst_wr_en_in = 1'($urandom_range(0, 1));
    mem_read_in = 1'($urandom_range(0, 1));
    exmem_wr_en = 1'($urandom_range(0, 1));
    exmem_wr_addr = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 5));
    exmem_wr_data = 16'($urandom);
    memwb_wr_en = 1'($urandom_range(0, 1));
    memwb_wr_addr = 4'($urandom_range(0, 5));
    memwb_wr_data = 16'($urandom);
  endtask

  initial begin
    rst = 1;
    drive_idle();
    m = BUBBLE;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    check_comb("reset");
    rst = 0;

    // immediate path
    drive_id(2'b01, 4'h0, 16'h0, 16'hFFF5, 4'h1, 1, 0);
    step("imm");
    check("imm.literal", op_b, 16'hFFF5);

    // double forward
    drive_idle();
    drive_id(2'b00, 4'h3, 16'h0001, 16'h0, 4'h4, 1, 0);
    step("fwd.cap");
    valid_in = 0; sel_b_in = 2'b10;
    exmem_wr_en = 1; exmem_wr_addr = 4'h3; exmem_wr_data = 16'h00AA;
    memwb_wr_en = 1; memwb_wr_addr = 4'h3; memwb_wr_data = 16'h00BB;
    #1;
`ifdef OPB_FORWARD_EN
    check("fwd.both", op_b, 16'h00AA);
`else
    check("fwd.both", op_b, 16'h0001);
`endif
    exmem_wr_en = 0;
    #1;
`ifdef OPB_FORWARD_EN
    check("fwd.memwb", op_b, 16'h00BB);
`else
    check("fwd.memwb", op_b, 16'h0001);
`endif
    drive_idle();
    step("fwd.clear");

    // load-use hazard
    drive_id(2'b01, 4'h0, 16'h0, 16'h0, 4'h5, 1, 1);
    step("lu.load");
    drive_id(2'b00, 4'h5, 16'h0055, 16'h0, 4'h6, 1, 0);
    #1;
    check("lu.flag", {15'h0, load_use_stall}, 16'h1);
    step("lu.bubble");
    check("lu.bubble_opb", op_b, 16'h0);
    check("lu.bubble_valid", {15'h0, valid_q}, 16'h0);
    check("lu.cleared", {15'h0, load_use_stall}, 16'h0);
    step("lu.capture");
    check("lu.capture_opb", op_b, 16'h0055);

    // flush beats stall, then stall holds op_b
    stall = 1; flush = 1;
    step("flush_stall");
    check("flush_stall.valid", {15'h0, valid_q}, 16'h0);
    check("flush_stall.sel", {14'h0, sel_b_q}, 16'h2);
    stall = 0; flush = 0;
    drive_id(2'b01, 4'h0, 16'h0, 16'h1234, 4'h2, 0, 0);
    step("hold.cap");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_id(2'b01, 4'h1, 16'($urandom), 16'($urandom), 4'h3, 1, 0);
      step("hold");
      check("hold.literal", op_b, 16'h1234);
    end
    drive_idle();
    step("hold.release");

    // widened RAW detection without forwarding
    exmem_wr_en = 1; exmem_wr_addr = 4'h2; exmem_wr_data = 16'($urandom);
    drive_id(2'b00, 4'h2, 16'h0, 16'h0, 4'h7, 0, 0);
    #1;
`ifdef OPB_FORWARD_EN
    check("raw.sel00", {15'h0, load_use_stall}, 16'h0);
`else
    check("raw.sel00", {15'h0, load_use_stall}, 16'h1);
`endif
    sel_b_in = 2'b01;
    #1;
    check("raw.sel01", {15'h0, load_use_stall}, 16'h0);
    drive_idle();

    // async reset while stalled with a pending hazard
    drive_id(2'b01, 4'h0, 16'h0, 16'hABCD, 4'h7, 1, 1);
    step("rst.cap");
    stall = 1;
    drive_id(2'b00, 4'h7, 16'h0, 16'h0, 4'h1, 1, 0);
    #1;
    check("rst.hazard", {15'h0, load_use_stall}, 16'h1);
    rst = 1;
    #1;
    m = BUBBLE;
    check("rst.opb", op_b, 16'h0);
    check("rst.valid", {15'h0, valid_q}, 16'h0);
    check("rst.sel", {14'h0, sel_b_q}, 16'h2);
    check("rst.lus", {15'h0, load_use_stall}, 16'h0);
    step("rst.held");
    rst = 0;
    drive_idle();
    step("rst.release");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
